// File: rtl/traffic_phase_timer.sv
// Phase-duration timer and watchdog feeding the traffic-light controller's timer/timer_mia inputs.
// Optional pedestrian request latching is enabled by defining TRAFFIC_TIMER_PED_EN.
module traffic_phase_timer #(
    parameter int CNT_W            = 16,
    parameter int RED_CYCLES       = 20,
    parameter int GREEN_CYCLES     = 30,
    parameter int YELLOW_CYCLES    = 5,
    parameter int WATCHDOG_CYCLES  = 8,
    parameter int PED_GREEN_CYCLES = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] state,
    input  logic       ped_walk_button,
    output logic       timer,
    output logic       timer_mia,
    output logic       walk
);

    typedef enum logic [1:0] {
        LOAD     = 2'd0,
        COUNT    = 2'd1,
        ACK_WAIT = 2'd2,
        HOLD     = 2'd3
    } fsm_e;

    localparam logic [1:0] ST_RED    = 2'b00;
    localparam logic [1:0] ST_GREEN  = 2'b01;
    localparam logic [1:0] ST_YELLOW = 2'b10;
    localparam logic [1:0] ST_FAULT  = 2'b11;

    localparam logic [CNT_W-1:0] RED_M1    = CNT_W'(RED_CYCLES - 1);
    localparam logic [CNT_W-1:0] GREEN_M1  = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] YELLOW_M1 = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] WD_M1     = CNT_W'(WATCHDOG_CYCLES - 1);
    localparam logic [CNT_W-1:0] PED_M1    = CNT_W'(PED_GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    fsm_e             fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic [1:0]       last_state_q, last_state_d;
    logic             timer_q, timer_d;
    logic             timer_mia_q, timer_mia_d;
    logic             mismatch;
    logic             ped_trunc;

    // Counter preload is D-1 so that D count cycles elapse before the pulse edge.
    function automatic logic [CNT_W-1:0] phase_len(input logic [1:0] s);
        case (s)
            ST_GREEN:  return GREEN_M1;
            ST_YELLOW: return YELLOW_M1;
            default:   return RED_M1;
        endcase
    endfunction

    assign mismatch = (state != last_state_q);

    always_comb begin
        fsm_d        = fsm_q;
        cnt_d        = cnt_q;
        wd_d         = wd_q;
        last_state_d = last_state_q;
        timer_d      = 1'b0;
        timer_mia_d  = timer_mia_q;
        case (fsm_q)
            LOAD: begin
                if (state == ST_FAULT) begin
                    fsm_d = HOLD;
                end else begin
                    cnt_d        = phase_len(state);
                    last_state_d = state;
                    fsm_d        = COUNT;
                end
            end
            COUNT: begin
                // An external override wins over an expiring count: no pulse.
                if (mismatch) begin
                    fsm_d = LOAD;
                end else if (cnt_q == '0) begin
                    timer_d = 1'b1;
                    wd_d    = '0;
                    fsm_d   = ACK_WAIT;
                end else if (ped_trunc) begin
                    cnt_d = PED_M1;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            ACK_WAIT: begin
                if (mismatch) begin
                    fsm_d = LOAD;
                end else if (wd_q == WD_M1) begin
                    timer_mia_d = 1'b1;
                    fsm_d       = HOLD;
                end else begin
                    wd_d = wd_q + ONE;
                end
            end
            HOLD: begin
                // A latched fault parks here until reset.
                if (!timer_mia_q && (state != ST_FAULT)) begin
                    fsm_d = LOAD;
                end
            end
            default: fsm_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q        <= LOAD;
            cnt_q        <= '0;
            wd_q         <= '0;
            last_state_q <= ST_RED;
            timer_q      <= 1'b0;
            timer_mia_q  <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            cnt_q        <= cnt_d;
            wd_q         <= wd_d;
            last_state_q <= last_state_d;
            timer_q      <= timer_d;
            timer_mia_q  <= timer_mia_d;
        end
    end

    assign timer     = timer_q;
    assign timer_mia = timer_mia_q;

`ifdef TRAFFIC_TIMER_PED_EN
    logic walk_q, walk_d;
    logic ped_req_q, ped_req_d;

    assign ped_trunc = (last_state_q == ST_GREEN) && ped_req_q && (cnt_q > PED_M1);

    always_comb begin
        walk_d    = walk_q;
        ped_req_d = ped_req_q;
        if ((fsm_q == LOAD) && (state != ST_FAULT)) begin
            if (state == ST_RED) begin
                if (ped_req_q) begin
                    walk_d    = 1'b1;
                    ped_req_d = 1'b0;
                end
            end else begin
                walk_d = 1'b0;
            end
        end
        if (fsm_d == HOLD) begin
            walk_d = 1'b0;
        end
        // A press during a walk phase is kept for the next RED.
        if (ped_walk_button) begin
            ped_req_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            walk_q    <= 1'b0;
            ped_req_q <= 1'b0;
        end else begin
            walk_q    <= walk_d;
            ped_req_q <= ped_req_d;
        end
    end

    assign walk = walk_q;
`else
    logic unused_ped_button;

    assign unused_ped_button = ped_walk_button;
    assign ped_trunc         = 1'b0;
    assign walk              = 1'b0;
`endif

endmodule
